// File: rtl/mem_perf_scanout.sv
// Memory perf-counter snapshot and scan-out: captures all counters in one cycle,
// then streams the frozen words over valid/ready, one-shot or periodically.

module mem_perf_scanout_word #(
   parameter int W = 44
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         cap_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);
   logic [W-1:0] word_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)   word_q <= '0;
      else if (cap_i) word_q <= d_i;
   end

   assign q_o = word_q;
endmodule

module mem_perf_scanout #(
   parameter int NUM_CTRS       = 8,
   parameter int CTR_WIDTH      = 44,
   parameter int INTERVAL_WIDTH = 16,
   parameter int OVR_WIDTH      = 8
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic [NUM_CTRS*CTR_WIDTH-1:0]     ctrs_in,
   input  logic                              start_valid,
   output logic                              start_ready,
   input  logic [INTERVAL_WIDTH-1:0]         interval,
   input  logic                              stop,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [CTR_WIDTH-1:0]              out_data,
   output logic [$clog2(NUM_CTRS)-1:0]       out_idx,
   output logic                              out_last,
   output logic                              busy,
   output logic [OVR_WIDTH-1:0]              overrun_cnt
);
   localparam int IDX_W = $clog2(NUM_CTRS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CTRS - 1);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT} state_e;

   state_e                              state_q, state_d;
   logic [IDX_W-1:0]                    idx_q, idx_d;
   logic [INTERVAL_WIDTH-1:0]           ival_q, ival_d;
   logic [INTERVAL_WIDTH-1:0]           timer_q, timer_d;
   logic                                stop_pend_q, stop_pend_d;
   logic [OVR_WIDTH-1:0]                ovr_q, ovr_d;
   logic                                snap_en;
   logic [NUM_CTRS-1:0][CTR_WIDTH-1:0]  ctrs_w, snap_q;

   logic periodic, expiry, hs, at_last;

   assign ctrs_w   = ctrs_in;
   assign periodic = (ival_q != '0);
   assign expiry   = (state_q != S_IDLE) && periodic && (timer_q == '0);
   assign hs       = (state_q == S_STREAM) && out_ready;
   assign at_last  = (idx_q == LAST_IDX);

   // One capture register per counter word, all enabled by the same strobe
   for (genvar i = 0; i < NUM_CTRS; i++) begin : g_word
      mem_perf_scanout_word #(.W(CTR_WIDTH)) u_word (
         .clk     (clk),
         .reset_n (reset_n),
         .cap_i   (snap_en),
         .d_i     (ctrs_w[i]),
         .q_o     (snap_q[i])
      );
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      ival_d      = ival_q;
      timer_d     = timer_q;
      stop_pend_d = stop_pend_q;
      ovr_d       = ovr_q;
      snap_en     = 1'b0;

      // Free-running period timer; expiries land every ival_q cycles after a snapshot
      if (state_q != S_IDLE && periodic)
         timer_d = expiry ? ival_q - 1'b1 : timer_q - 1'b1;

      case (state_q)
         S_IDLE: begin
            if (start_valid) begin
               ival_d      = interval;
               snap_en     = 1'b1;
               idx_d       = '0;
               timer_d     = (interval != '0) ? interval - 1'b1 : '0;
               stop_pend_d = 1'b0;
               state_d     = S_STREAM;
            end
         end
         S_STREAM: begin
            if (stop) stop_pend_d = 1'b1;
            if (hs && at_last) begin
               // stop wins so back-to-back periodic streams can still be ended
               if (stop_pend_q || stop) begin
                  stop_pend_d = 1'b0;
                  state_d     = S_IDLE;
               end else if (expiry) begin
                  snap_en = 1'b1;
                  idx_d   = '0;
               end else if (!periodic) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_WAIT;
               end
            end else begin
               if (hs) idx_d = idx_q + 1'b1;
               if (expiry && ovr_q != '1) ovr_d = ovr_q + 1'b1;
            end
         end
         S_WAIT: begin
            if (stop) begin
               stop_pend_d = 1'b0;
               state_d     = S_IDLE;
            end else if (expiry) begin
               snap_en = 1'b1;
               idx_d   = '0;
               state_d = S_STREAM;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         ival_q      <= '0;
         timer_q     <= '0;
         stop_pend_q <= 1'b0;
         ovr_q       <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         ival_q      <= ival_d;
         timer_q     <= timer_d;
         stop_pend_q <= stop_pend_d;
         ovr_q       <= ovr_d;
      end
   end

   assign start_ready = (state_q == S_IDLE);
   assign out_valid   = (state_q == S_STREAM);
   assign out_idx     = idx_q;
   assign out_data    = snap_q[idx_q];
   assign out_last    = out_valid && at_last;
   assign busy        = (state_q != S_IDLE);
   assign overrun_cnt = ovr_q;
endmodule
